// File: rtl/alarm_sounder_pkg.sv
// Shared alarm definitions: state encoding and counter width helper.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package alarm_sounder_pkg;

   // State encoding shared with the alarm settings block.
   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_RINGING = 2'd1,
      ST_SNOOZE  = 2'd2
   } alarm_state_t;

   // Width of a seconds counter that must reach max(a, b).
   function automatic int sec_cnt_width(input int a, input int b);
      return $clog2(((a > b) ? a : b) + 1);
   endfunction

endpackage

// File: rtl/alarm_sounder_tone_gen.sv
// Square-wave tone source: toggles tone_out every TONE_DIV cycles while en is high.
// Latency: first toggle TONE_DIV cycles after en rises; counter and output clear when en drops.
// Backpressure: none, free-running while enabled.
module tone_gen #(
   parameter int TONE_DIV = 5
) (
   input  logic sys_clk,
   input  logic rst_n,
   input  logic en,
   output logic tone_out
);

   localparam int CW = (TONE_DIV > 1) ? $clog2(TONE_DIV) : 1;

   logic [CW-1:0] cnt;
   logic          tone_sq;

   // Divide sys_clk down; hold everything cleared while not enabled.
   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt     <= '0;
         tone_sq <= 1'b0;
      end else if (!en) begin
         cnt     <= '0;
         tone_sq <= 1'b0;
      end else if (cnt == CW'(TONE_DIV - 1)) begin
         cnt     <= '0;
         tone_sq <= ~tone_sq;
      end else begin
         cnt     <= cnt + CW'(1);
      end
   end

   assign tone_out = tone_sq;

endmodule

// File: rtl/alarm_sounder.sv
// Alarm sounder: trigger edge -> gated 1 s on / 1 s off tone, with snooze, off and auto-silence.
// Latency: state outputs change on the edge sampling the event; buzzer_out lags tone by one cycle.
// Backpressure: none; events not applicable in the current state are dropped.
module alarm_sounder #(
   parameter int SYS_CLK_HZ       = 100_000_000,
   parameter int TONE_HZ          = 2000,
   parameter int SNOOZE_SEC       = 300,
   parameter int RING_TIMEOUT_SEC = 60,
   parameter int MAX_SNOOZE       = 3
) (
   input  logic                            sys_clk,
   input  logic                            rst_n,
   input  logic                            clk_1hz_en,
   input  logic                            alarm_trigger_in,
   input  logic                            snooze_btn,
   input  logic                            alarm_off_btn,
   output logic                            buzzer_out,
   output logic                            alarm_active_out,
   output logic                            snooze_active_out,
   output logic [$clog2(MAX_SNOOZE+1)-1:0] snooze_count_out
);

   import alarm_sounder_pkg::*;

   localparam int TONE_DIV = SYS_CLK_HZ / (2 * TONE_HZ);
   localparam int SEC_W    = sec_cnt_width(SNOOZE_SEC, RING_TIMEOUT_SEC);
   localparam int SNZ_W    = $clog2(MAX_SNOOZE + 1);

   alarm_state_t state, state_nxt;
   logic [SEC_W-1:0] sec_cnt, sec_nxt;
   logic [SNZ_W-1:0] snooze_cnt, snz_nxt;
   logic             beep_on, beep_nxt;
   logic             trig_q, snz_q, off_q;
   logic             trig_ev, snz_ev, off_ev;
   logic             tone_sq;

   // Input history for rising-edge detection; reset high so held inputs do not fire.
   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         trig_q <= 1'b1;
         snz_q  <= 1'b1;
         off_q  <= 1'b1;
      end else begin
         trig_q <= alarm_trigger_in;
         snz_q  <= snooze_btn;
         off_q  <= alarm_off_btn;
      end
   end

   assign trig_ev = alarm_trigger_in & ~trig_q;
   assign snz_ev  = snooze_btn & ~snz_q;
   assign off_ev  = alarm_off_btn & ~off_q;

   // FSM and per-event counter registers.
   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_IDLE;
         sec_cnt    <= '0;
         beep_on    <= 1'b0;
         snooze_cnt <= '0;
      end else begin
         state      <= state_nxt;
         sec_cnt    <= sec_nxt;
         beep_on    <= beep_nxt;
         snooze_cnt <= snz_nxt;
      end
   end

   // Next state: off beats snooze beats tick beats trigger; inapplicable events fall through.
   always_comb begin
      state_nxt = state;
      sec_nxt   = sec_cnt;
      beep_nxt  = beep_on;
      snz_nxt   = snooze_cnt;
      case (state)
         ST_IDLE: begin
            if (trig_ev) begin
               state_nxt = ST_RINGING;
               sec_nxt   = '0;
               beep_nxt  = 1'b1;
               snz_nxt   = '0;
            end
         end
         ST_RINGING: begin
            if (off_ev) begin
               state_nxt = ST_IDLE;
               snz_nxt   = '0;
            end else if (snz_ev && (snooze_cnt < SNZ_W'(MAX_SNOOZE))) begin
               state_nxt = ST_SNOOZE;
               sec_nxt   = '0;
               snz_nxt   = snooze_cnt + SNZ_W'(1);
            end else if (clk_1hz_en) begin
               if (sec_cnt == SEC_W'(RING_TIMEOUT_SEC - 1)) begin
                  state_nxt = ST_IDLE;
                  snz_nxt   = '0;
               end else begin
                  sec_nxt  = sec_cnt + SEC_W'(1);
                  beep_nxt = ~beep_on;
               end
            end
         end
         ST_SNOOZE: begin
            if (off_ev) begin
               state_nxt = ST_IDLE;
               snz_nxt   = '0;
            end else if (clk_1hz_en) begin
               if (sec_cnt == SEC_W'(SNOOZE_SEC - 1)) begin
                  state_nxt = ST_RINGING;
                  sec_nxt   = '0;
                  beep_nxt  = 1'b1;
               end else begin
                  sec_nxt = sec_cnt + SEC_W'(1);
               end
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   tone_gen #(
      .TONE_DIV (TONE_DIV)
   ) u_tone (
      .sys_clk  (sys_clk),
      .rst_n    (rst_n),
      .en       (state == ST_RINGING),
      .tone_out (tone_sq)
   );

   // Gate the tone by the beep cadence and register it for a glitch-free pin.
   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) buzzer_out <= 1'b0;
      else        buzzer_out <= tone_sq & beep_on & (state == ST_RINGING);
   end

   assign alarm_active_out  = (state != ST_IDLE);
   assign snooze_active_out = (state == ST_SNOOZE);
   assign snooze_count_out  = snooze_cnt;

endmodule

// File: tb/tb_alarm_sounder.sv
// Bench for alarm_sounder: scripted scenarios plus random button traffic vs. a behavioural model.
// Latency: model tracks outputs cycle by cycle, checked on the falling edge.
// Backpressure: n/a.
module tb_alarm_sounder;

   localparam int TONE_DIV = 5;
   localparam int SNZ_SEC  = 3;
   localparam int RING_SEC = 5;
   localparam int MAX_SNZ  = 2;

   logic       sys_clk = 1'b0;
   logic       rst_n;
   logic       clk_1hz_en;
   logic       trig, snz, off;
   logic       buzzer_out, alarm_active_out, snooze_active_out;
   logic [1:0] snooze_count_out;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   // Model: alarm phase, seconds elapsed in phase, tone phase, last-seen button levels.
   typedef enum int {M_OFF, M_RING, M_SNOOZE} phase_t;
   phase_t m_phase;
   int     m_secs, m_used, m_ring_cycles;
   bit     m_loud, m_buzz;
   bit     m_tl, m_sl, m_ol;

   alarm_sounder #(
      .SYS_CLK_HZ       (1000),
      .TONE_HZ          (100),
      .SNOOZE_SEC       (SNZ_SEC),
      .RING_TIMEOUT_SEC (RING_SEC),
      .MAX_SNOOZE       (MAX_SNZ)
   ) dut (
      .sys_clk           (sys_clk),
      .rst_n             (rst_n),
      .clk_1hz_en        (clk_1hz_en),
      .alarm_trigger_in  (trig),
      .snooze_btn        (snz),
      .alarm_off_btn     (off),
      .buzzer_out        (buzzer_out),
      .alarm_active_out  (alarm_active_out),
      .snooze_active_out (snooze_active_out),
      .snooze_count_out  (snooze_count_out)
   );

   always #5 sys_clk = ~sys_clk;

   task automatic chk(input string tag, input int got, input int exp);
      total++;
      if (got != exp) begin
         bad++;
         $display("FAIL %s got=%0d exp=%0d cyc=%0d", tag, got, exp, cyc);
      end
   endtask

   task automatic model_reset();
      m_phase = M_OFF; m_secs = 0; m_used = 0; m_ring_cycles = 0;
      m_loud = 0; m_buzz = 0; m_tl = 1; m_sl = 1; m_ol = 1;
   endtask

   // One clock edge of the model, using the input levels present at that edge.
   task automatic model_step();
      bit t_rise, s_rise, o_rise;
      bit tone_level;
      if (!rst_n) begin
         model_reset();
         return;
      end
      t_rise = trig && !m_tl;
      s_rise = snz && !m_sl;
      o_rise = off && !m_ol;
      m_tl = trig; m_sl = snz; m_ol = off;
      // Tone flips each TONE_DIV ringing cycles, starting low on entry to ringing.
      tone_level = ((m_ring_cycles / TONE_DIV) % 2) == 1;
      m_buzz = (m_phase == M_RING) && m_loud && tone_level;
      m_ring_cycles = (m_phase == M_RING) ? m_ring_cycles + 1 : 0;
      if (m_phase == M_OFF) begin
         if (t_rise) begin
            m_phase = M_RING; m_secs = 0; m_loud = 1; m_used = 0;
         end
      end else if (o_rise) begin
         m_phase = M_OFF; m_used = 0;
      end else if (m_phase == M_RING) begin
         if (s_rise && m_used < MAX_SNZ) begin
            m_phase = M_SNOOZE; m_secs = 0; m_used++;
         end else if (clk_1hz_en) begin
            m_secs++;
            if (m_secs == RING_SEC) begin
               m_phase = M_OFF; m_used = 0;
            end else begin
               m_loud = !m_loud;
            end
         end
      end else if (clk_1hz_en) begin
         m_secs++;
         if (m_secs == SNZ_SEC) begin
            m_phase = M_RING; m_secs = 0; m_loud = 1;
         end
      end
   endtask

   // Advance one clock (caller sits on a falling edge) and compare all outputs.
   task automatic cycle();
      clk_1hz_en = (cyc % 100) == 99;
      @(posedge sys_clk);
      model_step();
      cyc++;
      @(negedge sys_clk);
      chk("active", alarm_active_out, m_phase != M_OFF);
      chk("snooze", snooze_active_out, m_phase == M_SNOOZE);
      chk("count", snooze_count_out, m_used);
      chk("buzzer", buzzer_out, m_buzz);
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) cycle();
   endtask

   task automatic pulse_trig();
      trig = 1; cycle(); trig = 0;
   endtask

   task automatic pulse_snz();
      snz = 1; cycle(); snz = 0;
   endtask

   task automatic pulse_off();
      off = 1; cycle(); off = 0;
   endtask

   initial begin
      rst_n = 0; clk_1hz_en = 0; trig = 0; snz = 0; off = 0;
      model_reset();
      repeat (3) @(negedge sys_clk);
      chk("rst_active", alarm_active_out, 0);
      chk("rst_snooze", snooze_active_out, 0);
      chk("rst_count", snooze_count_out, 0);
      chk("rst_buzzer", buzzer_out, 0);
      rst_n = 1;
      run(5);

      // Ring to timeout with no buttons; watch tone cadence.
      pulse_trig();
      run(620);

      // Snooze, re-ring, second snooze, refused third snooze, then off.
      pulse_trig();
      run(150);
      pulse_snz();
      run(350);
      pulse_snz();
      run(350);
      pulse_snz();
      run(60);
      pulse_off();
      run(20);

      // Off and snooze together while ringing.
      pulse_trig();
      run(40);
      snz = 1; off = 1; cycle(); snz = 0; off = 0;
      run(20);

      // Trigger held high through reset release must not ring.
      rst_n = 0; trig = 1;
      run(3);
      rst_n = 1;
      run(150);
      trig = 0;
      run(5);

      // Asynchronous reset in the middle of a snooze.
      pulse_trig();
      run(30);
      pulse_snz();
      run(40);
      #2 rst_n = 0;
      #1;
      chk("arst_active", alarm_active_out, 0);
      chk("arst_snooze", snooze_active_out, 0);
      chk("arst_count", snooze_count_out, 0);
      chk("arst_buzzer", buzzer_out, 0);
      run(3);
      rst_n = 1;
      run(2);
      pulse_trig();
      run(30);

      // Random button traffic.
      for (int i = 0; i < 4000; i++) begin
         trig = ($urandom_range(0, 199) == 0) ? 1'b1 : (trig && $urandom_range(0, 3) != 0);
         snz  = ($urandom_range(0, 149) == 0) ? 1'b1 : (snz && $urandom_range(0, 3) != 0);
         off  = ($urandom_range(0, 499) == 0) ? 1'b1 : (off && $urandom_range(0, 3) != 0);
         cycle();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
